// File: rtl/seq_booth_multiplier_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
interface seq_booth_multiplier_if #(parameter int N = 32);
    logic           start;
    logic           is_signed;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           flush;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (output start, is_signed, a, b, flush,
                    input  ready, busy, done, product);
    modport slave  (input  start, is_signed, a, b, flush,
                    output ready, busy, done, product);
endinterface

// File: rtl/seq_booth_multiplier.sv
// Radix-2 Booth multiplier, one step per clock, full 2N-bit signed/unsigned product.
module seq_booth_multiplier #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_booth_multiplier_if.slave bus
);
    localparam int W  = N + 1;
    localparam int PW = 2 * W + 1;
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d;

    logic [W-1:0]     a_ext, b_ext, upper;
    logic [PW-1:0]    p_step;

    // One extra bit keeps the most negative and full-range unsigned operands exact.
    assign a_ext = {bus.is_signed & bus.a[N-1], bus.a};
    assign b_ext = {bus.is_signed & bus.b[N-1], bus.b};

    always_comb begin
        upper = p_q[PW-1:W+1];
        case (p_q[1:0])
            2'b01:   upper = upper + mcand_q;
            2'b10:   upper = upper + (~mcand_q + W'(1));
            default: upper = p_q[PW-1:W+1];
        endcase
        p_step = {upper[W-1], upper, p_q[W:1]};
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    p_d     = {{W{1'b0}}, a_ext, 1'b0};
                    mcand_d = b_ext;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    p_d   = p_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        prod_d  = p_step[2*N:1];
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q == BUSY);
    assign bus.done    = (state_q == DONE);
    assign bus.product = prod_q;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Random and directed checks of seq_booth_multiplier against a latency/arithmetic model.
module tb_seq_booth_multiplier;
    localparam int N   = 32;
    localparam int W   = N + 1;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    seq_booth_multiplier_if #(.N(N)) bif();
    seq_booth_multiplier #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 running, 2 done; tracks what the outputs must be each cycle.
    int          m_mode = 0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_prod <= '0;
        end else begin
            case (m_mode)
                0: if (bif.start) begin
                    m_pend <= ref_mul(bif.is_signed, bif.a, bif.b);
                    m_left <= W;
                    m_mode <= 1;
                end
                1: if (bif.flush) m_mode <= 0;
                   else if (m_left == 1) begin
                       m_prod <= m_pend;
                       m_mode <= 2;
                   end else m_left <= m_left - 1;
                default: m_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 64'(bif.ready), 64'(m_mode == 0));
            chk("busy", 64'(bif.busy), 64'(m_mode == 1));
            chk("done", 64'(bif.done), 64'(m_mode == 2));
            chk("product", bif.product, m_prod);
            if (bif.done) done_cnt++;
        end
    end

    // Called at a negedge; returns negedges from acceptance to done (0 if flushed/timed out).
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input int flush_at, output int lat);
        int g = 0;
        int n = 0;
        lat = 0;
        while (!bif.ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bif.ready) begin
            chk("ready_timeout", 64'(bif.ready), 64'd1);
            return;
        end
        bif.start = 1'b1; bif.is_signed = s; bif.a = a; bif.b = b; bif.flush = fl;
        while (n < 100) begin
            @(negedge clk);
            n++;
            bif.flush = (flush_at > 0 && n == flush_at);
            if (n == 1) begin
                bif.start = 1'b0;
                bif.a = $urandom;
                bif.b = $urandom;
            end
            if (bif.done) begin
                lat = n;
                return;
            end
            if (flush_at > 0 && n > flush_at && bif.ready) return;
        end
        chk("done_timeout", 64'(n), 64'(LAT));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, d0;
        logic [63:0] keep;
        logic s;
        logic [31:0] ra, rb;
        bif.start = 0; bif.is_signed = 0; bif.a = '0; bif.b = '0; bif.flush = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bif.ready), 64'd1);
        chk("rst_busy", 64'(bif.busy), 64'd0);
        chk("rst_done", 64'(bif.done), 64'd0);
        chk("rst_product", bif.product, 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_ready", 64'(bif.ready), 64'd1);
        chk("idle_product", bif.product, 64'd0);

        chk("model_pin_signed", ref_mul(1'b1, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model_pin_unsigned", ref_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);

        do_op(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, lat);
        chk("lat_m3x5", 64'(lat), 64'(LAT));
        chk("prod_m3x5", bif.product, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat);
        chk("prod_umax", bif.product, 64'hFFFF_FFFE_0000_0001);
        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat);
        chk("prod_sm1", bif.product, 64'h0000_0000_0000_0001);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, lat);
        chk("prod_smin", bif.product, 64'h4000_0000_0000_0000);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, lat);
        chk("prod_umin", bif.product, 64'h4000_0000_0000_0000);

        // Flush mid-operation with ignored start pulses while busy.
        @(negedge clk);
        d0 = done_cnt;
        keep = bif.product;
        bif.start = 1; bif.is_signed = 0; bif.a = 7; bif.b = 6;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bif.start = (c == 5 || c == 8);
            if (bif.start) begin bif.a = $urandom; bif.b = $urandom; end
            bif.flush = (c == 10);
        end
        bif.start = 0; bif.flush = 0;
        chk("flush_no_done", 64'(done_cnt), 64'(d0));
        chk("flush_product", bif.product, keep);
        chk("flush_ready", 64'(bif.ready), 64'd1);
        d0 = done_cnt;
        do_op(1'b0, 32'd7, 32'd6, 1'b1, 0, lat);
        @(negedge clk);
        chk("start_wins_prod", bif.product, 64'd42);
        chk("start_wins_done_once", 64'(done_cnt), 64'(d0 + 1));

        // Asynchronous reset mid-operation, then immediate restart.
        bif.start = 1; bif.is_signed = 1; bif.a = 32'd3; bif.b = 32'hFFFF_FFFC;
        @(negedge clk);
        bif.start = 0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(bif.ready), 64'd1);
        chk("arst_busy", 64'(bif.busy), 64'd0);
        chk("arst_done", 64'(bif.done), 64'd0);
        chk("arst_product", bif.product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b1, 32'd3, 32'hFFFF_FFFC, 1'b0, 0, lat);
        chk("arst_lat", 64'(lat), 64'(LAT));
        chk("arst_prod", bif.product, 64'hFFFF_FFFF_FFFF_FFF4);

        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 4) == 0) begin
                do_op(s, ra, rb, 1'b0, int'($urandom_range(1, W - 1)), lat);
            end else begin
                do_op(s, ra, rb, 1'($urandom_range(0, 1)), 0, lat);
                chk("rand_lat", 64'(lat), 64'(LAT));
                chk("rand_prod", bif.product, ref_mul(s, ra, rb));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
